// File: rtl/chan_mux_rr_if.sv
// Channel multiplexer bus: per-channel upstream valid/ready/data plus the
// single registered downstream valid/ready/data/channel port.
// "slave" is the multiplexer's view; "master" is the surrounding logic's view.
interface chan_mux_rr_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 8
);
    localparam int CW = $clog2(NCH);

    logic                  mode;
    logic [CW-1:0]         sel;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CW-1:0]         out_chan;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel to one multiplexer with a single output register.
// mode=0 grants the channel given by sel; mode=1 grants round-robin starting
// at an internal pointer that advances past each granted channel.
// Optional build macro MUX_STATS_EN adds a saturating 16-bit count of
// accepted output words on port xfer_cnt.
module chan_mux_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    chan_mux_rr_if.slave  bus
`ifdef MUX_STATS_EN
    ,
    output logic [15:0]   xfer_cnt
`endif
);
    localparam int CW = $clog2(NCH);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     ptr_reg, ptr_next;
    logic [WIDTH-1:0]  data_reg;
    logic [CW-1:0]     chan_reg;

    logic              load;
    logic              rr_found;
    logic [CW-1:0]     rr_idx;
    logic [CW:0]       cand;
    logic              fx_ok;
    logic              grant_any;
    logic [CW-1:0]     grant_idx;
    logic [NCH-1:0]    in_ready_w;
    logic              in_xfer;
    logic [WIDTH-1:0]  chan_data [NCH];

    // Slice the flat input bus into one word per channel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can take a word when empty or when it is being drained.
    assign load = (state_reg == EMPTY) || bus.out_ready;

    // Round-robin search: first valid channel at ptr, ptr+1, ... wrapping to 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr_reg} + (CW+1)'(i);
            if (cand >= (CW+1)'(NCH))
                cand = cand - (CW+1)'(NCH);
            if (!rr_found && bus.in_valid[cand[CW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[CW-1:0];
            end
        end
    end

    // Fixed mode offers ready to sel regardless of its valid; out-of-range sel grants nothing.
    assign fx_ok     = (32'(bus.sel) < NCH);
    assign grant_any = bus.mode ? rr_found : fx_ok;
    assign grant_idx = bus.mode ? rr_idx : bus.sel;

    // One-hot ready, forced low while in reset or when the register cannot load.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready_w[gi] = rst_n && load && grant_any && (grant_idx == CW'(gi));
        end
    endgenerate

    assign bus.in_ready = in_ready_w;
    assign in_xfer      = |(in_ready_w & bus.in_valid);

    // Output register occupancy: fills on an input transfer, empties when drained with nothing new.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (in_xfer) state_next = FULL;
            FULL:  if (bus.out_ready && !in_xfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Pointer moves one past the granted channel only on a round-robin transfer.
    always_comb begin
        ptr_next = ptr_reg;
        if (bus.mode && in_xfer)
            ptr_next = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);
    end

    // State, pointer and output word; held data is discarded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            data_reg  <= '0;
            chan_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (in_xfer) begin
                data_reg <= chan_data[grant_idx];
                chan_reg <= grant_idx;
            end
        end
    end

    assign bus.out_data  = data_reg;
    assign bus.out_chan  = chan_reg;
    assign bus.out_valid = (state_reg == FULL);

`ifdef MUX_STATS_EN
    // Saturating count of words accepted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xfer_cnt <= 16'h0000;
        else if ((state_reg == FULL) && bus.out_ready && (xfer_cnt != 16'hFFFF))
            xfer_cnt <= xfer_cnt + 16'h0001;
    end
`endif

endmodule

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the data width per channel in bits.
REQ-002 The block SHALL have parameter NCH, default 8, meaning the channel count, legal range 2..16; local CW = clog2(NCH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-006 The block SHALL have port sel, input, CW bits: the channel index used in fixed mode.
REQ-007 The block SHALL have port in_data, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_valid, input, NCH bits: per-channel valid.
REQ-009 The block SHALL have port in_ready, output, NCH bits: per-channel ready, at most one bit high, combinational.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-011 The block SHALL have port out_chan, output, CW bits: source channel of out_data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: output register holds data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-014 With MUX_STATS_EN defined, the block SHALL have port xfer_cnt, output, 16 bits: accepted-output count.

Function
REQ-015 A transfer SHALL occur on any channel or output where valid and ready are both high at a rising edge.
REQ-016 The output register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 The load condition load = (EMPTY) or (FULL and out_ready) SHALL hold; in_ready SHALL be all-zero when load=0.
REQ-018 In fixed mode, in_ready[sel] SHALL equal load, and all other bits SHALL be 0.
REQ-019 In fixed mode with sel >= NCH, no channel SHALL be granted.
REQ-020 In round-robin mode, the granted channel SHALL be the first index g, searching ptr, ptr+1, ... with wrap to 0, such that in_valid[g]=1; in_ready[g] SHALL equal load.
REQ-021 After a round-robin input transfer from g, ptr SHALL become (g+1) mod NCH; otherwise ptr SHALL hold.
REQ-022 In fixed mode, ptr SHALL hold.
REQ-023 On an input transfer, out_data, out_chan and out_valid=1 SHALL load on the same edge, giving 1-cycle latency.
REQ-024 With FULL, out_ready=1 and a grant in the same cycle, the register SHALL be replaced with no bubble, sustaining 1 transfer/cycle.
REQ-025 With FULL, out_ready=1 and no grant, the state SHALL go to EMPTY with out_valid=0; out_data and out_chan SHALL hold their last values.
REQ-026 With FULL and out_ready=0, out_data, out_chan and out_valid SHALL stay stable.
REQ-027 A change of mode or sel SHALL affect only the next grant and SHALL never alter held output.
REQ-028 Upstream inputs SHALL NOT affect in_ready combinationally except through in_valid, mode, sel, ptr and out_ready; in_ready SHALL NOT depend on in_data.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-transfer, SHALL immediately force out_valid=0, out_data=0, out_chan=0, ptr=0 and xfer_cnt=0, discarding held data.
REQ-030 During reset, in_ready SHALL be all-zero.
REQ-031 The first grant SHALL occur on the first rising edge after deassertion.

Configuration
REQ-032 With macro MUX_STATS_EN defined, xfer_cnt SHALL increment by 1 on each output transfer (out_valid and out_ready) and saturate at 16'hFFFF.
REQ-033 Without MUX_STATS_EN, port xfer_cnt and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Fixed mode: mode=0, sel=5, in_valid=8'hFF, ch5=4'hA, out_ready=1 -> after 1 edge, out_data=4'hA, out_chan=5, in_ready=8'h20.
REQ-035 Round-robin: mode=1, in_valid=8'b1001_0010, out_ready=1 held -> out_chan sequence 1,4,7,1,4, ptr wraps 0 after 7.
REQ-036 Backpressure: FULL, out_ready=0 for 4 cycles while the valid channel data changes -> out_data/out_chan stable, in_ready=0; out_ready=1 -> next word loads the same edge, no bubble.
REQ-037 Illegal sel: mode=0, sel=3 with NCH=3 -> in_ready=0, out_valid stays 0.
REQ-038 Reset mid-operation: FULL holding 4'h7, drop rst_n between edges -> out_valid=0, out_data=0 immediately; after release, round-robin restarts from ch0.
REQ-039 Stats (MUX_STATS_EN): 70000 back-to-back output transfers -> xfer_cnt=16'hFFFF and holds.
